// File: rtl/memarb_pkg.sv
// Shared types and helpers for the unified-memory arbiter.
// Covers the FSM state encoding, the owner tag, the watchdog width and a saturating increment.
package memarb_pkg;

    typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT, ARB_WAIT, ARB_RESP} arb_state_t;
    typedef enum logic {OWNER_I, OWNER_D} arb_owner_t;

    localparam int WD_W     = 8;
    localparam int STARVE_W = 3;

    function automatic logic [STARVE_W-1:0] sat_inc(input logic [STARVE_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/arb_watchdog.sv
// Watchdog for outstanding memory transactions.
// Counts enabled cycles after a clear and flags expiry at TIMEOUT.
module arb_watchdog
    import memarb_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    logic [WD_W-1:0] r_count;

    assign o_expired = (r_count == WD_W'(TIMEOUT));

    // Holds at the terminal count so a stalled enable can never wrap back to zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expired) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single-port unified memory: fetch (read-only) and data (read/write).
// Data has priority, bounded by an anti-starvation counter; a watchdog aborts unacknowledged accesses.
//
//  state     | meaning
//  ARB_IDLE  | pick a winner, latch its address/we/wdata into mem_*
//  ARB_GRANT | mem_req raised, watchdog cleared
//  ARB_WAIT  | waiting for mem_ack or watchdog expiry
//  ARB_RESP  | one-cycle ack pulse to the winner
module mem_arbiter
    import memarb_pkg::*;
#(
    parameter int AW           = 32,
    parameter int DW           = 64,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_ack,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ack,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          timeout_err
);

    arb_state_t          r_state, w_next_state;
    arb_owner_t          r_owner;
    logic [STARVE_W-1:0] r_starve_cnt;
    logic                r_mem_req, r_mem_we, r_timeout_err;
    logic [AW-1:0]       r_mem_addr;
    logic [DW-1:0]       r_mem_wdata, r_i_rdata, r_d_rdata;
    logic                w_any_req, w_grant_d, w_wd_clear, w_wd_enable, w_wd_expired;

    assign w_any_req = i_req | d_req;
    assign w_grant_d = d_req && !(i_req && (r_starve_cnt == STARVE_W'(STARVE_LIMIT)));

    arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_wd_clear),
        .i_enable  (w_wd_enable),
        .o_expired (w_wd_expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_wd_clear   = 1'b0;
        w_wd_enable  = 1'b0;
        unique case (r_state)
            ARB_IDLE:  if (w_any_req) w_next_state = ARB_GRANT;
            ARB_GRANT: begin
                w_wd_clear   = 1'b1;
                w_next_state = ARB_WAIT;
            end
            ARB_WAIT: begin
                w_wd_enable = 1'b1;
                if (mem_ack || w_wd_expired) w_next_state = ARB_RESP;
            end
            ARB_RESP:  w_next_state = ARB_IDLE;
            default:   w_next_state = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_owner       <= OWNER_I;
            r_starve_cnt  <= '0;
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_i_rdata     <= '0;
            r_d_rdata     <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state == ARB_IDLE && w_any_req) begin
                r_mem_req <= 1'b1;
                if (w_grant_d) begin
                    r_owner     <= OWNER_D;
                    r_mem_we    <= d_we;
                    r_mem_addr  <= d_addr;
                    r_mem_wdata <= d_wdata;
                    if (i_req) r_starve_cnt <= sat_inc(r_starve_cnt);
                end else begin
                    r_owner      <= OWNER_I;
                    r_mem_we     <= 1'b0;
                    r_mem_addr   <= i_addr;
                    r_mem_wdata  <= '0;
                    r_starve_cnt <= '0;
                end
            end
            // An ack arriving in the same cycle as expiry still counts as a completion.
            if (r_state == ARB_WAIT) begin
                if (mem_ack) begin
                    r_mem_req <= 1'b0;
                    if (r_owner == OWNER_I) r_i_rdata <= mem_rdata;
                    else if (!r_mem_we)     r_d_rdata <= mem_rdata;
                end else if (w_wd_expired) begin
                    r_mem_req     <= 1'b0;
                    r_timeout_err <= 1'b1;
                end
            end
        end
    end

    assign i_ack       = (r_state == ARB_RESP) && (r_owner == OWNER_I);
    assign d_ack       = (r_state == ARB_RESP) && (r_owner == OWNER_D);
    assign i_rdata     = r_i_rdata;
    assign d_rdata     = r_d_rdata;
    assign mem_req     = r_mem_req;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign timeout_err = r_timeout_err;

endmodule
